// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind game tracker.
package mastermind_pkg;

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    WIN     = 2'b01,
    LOSE    = 2'b10
  } game_state_t;

  localparam logic [3:0] DISP_WIN  = 4'd8;
  localparam logic [3:0] DISP_LOSE = 4'd0;
  localparam int         PEG_W     = 3;

endpackage

// File: rtl/mastermind_game_tracker_if.sv
// Feedback/control bus between the peg-compare stage and the game tracker.
interface mastermind_game_tracker_if #(
  parameter int HW = 3
);
  logic          new_game;
  logic          fb_valid;
  logic [HW-1:0] fb_red;
  logic [HW-1:0] fb_white;
  logic          review_mode;
  logic          review_step;
  logic [3:0]    guess_count;
  logic [1:0]    game_state;
  logic [3:0]    disp_red;
  logic [3:0]    disp_white;
  logic          fb_err;

  modport master (
    output new_game, fb_valid, fb_red, fb_white, review_mode, review_step,
    input  guess_count, game_state, disp_red, disp_white, fb_err
  );

  modport slave (
    input  new_game, fb_valid, fb_red, fb_white, review_mode, review_step,
    output guess_count, game_state, disp_red, disp_white, fb_err
  );
endinterface

// File: rtl/mastermind_fb_history.sv
// Per-guess feedback register file: one synchronous write port, one asynchronous read port.
module mastermind_fb_history #(
  parameter int DEPTH = 8,
  parameter int W     = 6,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mastermind_game_tracker.sv
// Mastermind game tracker: guess counting, WIN/LOSE FSM and HEX feedback display.
// Optional history review paging is enabled by defining HISTORY_REVIEW_EN.
module mastermind_game_tracker
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8,
  parameter int PEGS        = 4,
  parameter int HW          = PEG_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  mastermind_game_tracker_if.slave bus
);
  localparam logic [HW:0]   L_PEGS_SUM = (HW+1)'(PEGS);
  localparam logic [HW-1:0] L_PEGS     = HW'(PEGS);
  localparam logic [3:0]    L_MAX      = 4'(MAX_GUESSES);

  game_state_t r_state, w_state_nxt;
  logic [3:0]  r_count, w_count_nxt, w_count_inc;
  logic [3:0]  r_live_red, r_live_white, w_live_red_nxt, w_live_white_nxt;
  logic [3:0]  r_disp_red, r_disp_white;
  logic        r_fb_err, w_err_nxt;
  logic [HW:0] w_sum;
  logic        w_legal, w_accept;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= L_MAX) ? v : v + 4'd1;
  endfunction

  always_comb begin
    w_sum            = {1'b0, bus.fb_red} + {1'b0, bus.fb_white};
    w_legal          = (w_sum <= L_PEGS_SUM);
    w_accept         = (r_state == PLAYING) && bus.fb_valid && !bus.new_game && w_legal;
    w_err_nxt        = (r_state == PLAYING) && bus.fb_valid && !bus.new_game && !w_legal;
    w_count_inc      = sat_inc(r_count);
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_live_red_nxt   = r_live_red;
    w_live_white_nxt = r_live_white;
    if (bus.new_game) begin
      w_state_nxt      = PLAYING;
      w_count_nxt      = 4'd0;
      w_live_red_nxt   = 4'd0;
      w_live_white_nxt = 4'd0;
    end else if (w_accept) begin
      w_count_nxt = w_count_inc;
      // A win on the final allowed guess must take priority over LOSE.
      if (bus.fb_red == L_PEGS) begin
        w_state_nxt      = WIN;
        w_live_red_nxt   = DISP_WIN;
        w_live_white_nxt = DISP_WIN;
      end else if (w_count_inc == L_MAX) begin
        w_state_nxt      = LOSE;
        w_live_red_nxt   = DISP_LOSE;
        w_live_white_nxt = DISP_LOSE;
      end else begin
        w_live_red_nxt   = 4'(bus.fb_red);
        w_live_white_nxt = 4'(bus.fb_white);
      end
    end
  end

`ifdef HISTORY_REVIEW_EN
  localparam int HAW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;

  logic [3:0]      r_rptr;
  logic [2*HW-1:0] w_rdata;
  logic            w_review;

  assign w_review = bus.review_mode && (r_count != 4'd0) && !bus.new_game;

  mastermind_fb_history #(
    .DEPTH (MAX_GUESSES),
    .W     (2*HW),
    .AW    (HAW)
  ) u_hist (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_count[HAW-1:0]),
    .i_wdata ({bus.fb_red, bus.fb_white}),
    .i_raddr (r_rptr[HAW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn || bus.new_game) begin
      r_rptr <= 4'd0;
    end else if (bus.review_step && (r_count != 4'd0)) begin
      r_rptr <= (r_rptr == r_count - 4'd1) ? 4'd0 : r_rptr + 4'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.review_mode, bus.review_step};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= PLAYING;
      r_count      <= 4'd0;
      r_live_red   <= 4'd0;
      r_live_white <= 4'd0;
      r_disp_red   <= 4'd0;
      r_disp_white <= 4'd0;
      r_fb_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_live_red   <= w_live_red_nxt;
      r_live_white <= w_live_white_nxt;
      r_fb_err     <= w_err_nxt;
`ifdef HISTORY_REVIEW_EN
      r_disp_red   <= w_review ? 4'(w_rdata[2*HW-1:HW]) : w_live_red_nxt;
      r_disp_white <= w_review ? 4'(w_rdata[HW-1:0])    : w_live_white_nxt;
`else
      r_disp_red   <= w_live_red_nxt;
      r_disp_white <= w_live_white_nxt;
`endif
    end
  end

  assign bus.guess_count = r_count;
  assign bus.game_state  = r_state;
  assign bus.disp_red    = r_disp_red;
  assign bus.disp_white  = r_disp_white;
  assign bus.fb_err      = r_fb_err;
endmodule

// File: tb/tb_mastermind_game_tracker.sv
// Directed self-checking bench for mastermind_game_tracker (review tests follow HISTORY_REVIEW_EN).
module tb_mastermind_game_tracker;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mastermind_game_tracker_if #(.HW(3)) bus ();

  mastermind_game_tracker #(.MAX_GUESSES(8), .PEGS(4), .HW(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic guess(input logic [2:0] r, input logic [2:0] w);
    bus.fb_valid = 1'b1; bus.fb_red = r; bus.fb_white = w;
    tick();
    bus.fb_valid = 1'b0; bus.fb_red = 3'd0; bus.fb_white = 3'd0;
  endtask

  task automatic new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_tests++; if (bus.guess_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.guess_count); end
    n_tests++; if (bus.game_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.game_state); end
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h00) begin n_fail++; $display("FAIL reset_disp got %h exp 00", {bus.disp_red, bus.disp_white}); end
    n_tests++; if (bus.fb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", bus.fb_err); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    guess(3'd2, 3'd1);
    n_tests++; if (bus.guess_count !== 4'd1) begin n_fail++; $display("FAIL basic_count got %0d exp 1", bus.guess_count); end
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h21) begin n_fail++; $display("FAIL basic_disp got %h exp 21", {bus.disp_red, bus.disp_white}); end
    n_tests++; if (bus.game_state !== 2'b00) begin n_fail++; $display("FAIL basic_state got %0d exp 0", bus.game_state); end
  endtask

  task automatic test_win();
    new_game();
    for (int i = 0; i < 7; i++) guess(3'd1, 3'd0);
    n_tests++; if (bus.guess_count !== 4'd7 || bus.game_state !== 2'b00) begin n_fail++; $display("FAIL win_pre count/state got %0d/%0d exp 7/0", bus.guess_count, bus.game_state); end
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h10) begin n_fail++; $display("FAIL win_pre_disp got %h exp 10", {bus.disp_red, bus.disp_white}); end
    guess(3'd4, 3'd0);
    n_tests++; if (bus.game_state !== 2'b01) begin n_fail++; $display("FAIL win_state got %0d exp 1", bus.game_state); end
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h88) begin n_fail++; $display("FAIL win_disp got %h exp 88", {bus.disp_red, bus.disp_white}); end
    n_tests++; if (bus.guess_count !== 4'd8) begin n_fail++; $display("FAIL win_count got %0d exp 8", bus.guess_count); end
    guess(3'd5, 3'd0);
    n_tests++; if (bus.guess_count !== 4'd8 || bus.fb_err !== 1'b0 || bus.game_state !== 2'b01) begin n_fail++; $display("FAIL win_ignore count/err/state got %0d/%0d/%0d exp 8/0/1", bus.guess_count, bus.fb_err, bus.game_state); end
  endtask

  task automatic test_lose();
    new_game();
    for (int i = 0; i < 7; i++) guess(3'd0, 3'd2);
    n_tests++; if (bus.game_state !== 2'b00) begin n_fail++; $display("FAIL lose_pre_state got %0d exp 0", bus.game_state); end
    guess(3'd0, 3'd2);
    n_tests++; if (bus.game_state !== 2'b10) begin n_fail++; $display("FAIL lose_state got %0d exp 2", bus.game_state); end
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h00 || bus.guess_count !== 4'd8) begin n_fail++; $display("FAIL lose_disp_count got %h/%0d exp 00/8", {bus.disp_red, bus.disp_white}, bus.guess_count); end
    guess(3'd1, 3'd1);
    n_tests++; if (bus.guess_count !== 4'd8 || bus.fb_err !== 1'b0) begin n_fail++; $display("FAIL lose_ignore count/err got %0d/%0d exp 8/0", bus.guess_count, bus.fb_err); end
    new_game();
    n_tests++; if (bus.guess_count !== 4'd0 || bus.game_state !== 2'b00) begin n_fail++; $display("FAIL lose_newgame count/state got %0d/%0d exp 0/0", bus.guess_count, bus.game_state); end
  endtask

  task automatic test_illegal();
    new_game();
    guess(3'd1, 3'd1);
    guess(3'd3, 3'd2);
    n_tests++; if (bus.fb_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %0d exp 1", bus.fb_err); end
    n_tests++; if (bus.guess_count !== 4'd1 || {bus.disp_red, bus.disp_white} !== 8'h11) begin n_fail++; $display("FAIL illegal_hold count/disp got %0d/%h exp 1/11", bus.guess_count, {bus.disp_red, bus.disp_white}); end
    tick();
    n_tests++; if (bus.fb_err !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %0d exp 0", bus.fb_err); end
    guess(3'd7, 3'd7);
    n_tests++; if (bus.fb_err !== 1'b1 || bus.guess_count !== 4'd1) begin n_fail++; $display("FAIL illegal_wide err/count got %0d/%0d exp 1/1", bus.fb_err, bus.guess_count); end
    guess(3'd2, 3'd2);
    n_tests++; if (bus.fb_err !== 1'b0 || bus.guess_count !== 4'd2 || {bus.disp_red, bus.disp_white} !== 8'h22) begin n_fail++; $display("FAIL legal_edge err/count/disp got %0d/%0d/%h exp 0/2/22", bus.fb_err, bus.guess_count, {bus.disp_red, bus.disp_white}); end
    bus.new_game = 1'b1;
    guess(3'd1, 3'd0);
    bus.new_game = 1'b0;
    n_tests++; if (bus.guess_count !== 4'd0 || bus.game_state !== 2'b00 || {bus.disp_red, bus.disp_white} !== 8'h00) begin n_fail++; $display("FAIL newgame_vs_fb count/state/disp got %0d/%0d/%h exp 0/0/00", bus.guess_count, bus.game_state, {bus.disp_red, bus.disp_white}); end
  endtask

`ifdef HISTORY_REVIEW_EN
  task automatic step();
    bus.review_step = 1'b1;
    tick();
    bus.review_step = 1'b0;
    tick();
  endtask

  task automatic test_review();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h20; exp_seq[2] = 8'h03; exp_seq[3] = 8'h11;
    new_game();
    bus.review_step = 1'b1;
    tick();
    bus.review_step = 1'b0;
    guess(3'd1, 3'd1); guess(3'd2, 3'd0); guess(3'd0, 3'd3);
    bus.review_mode = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      n_tests++; if ({bus.disp_red, bus.disp_white} !== exp_seq[i]) begin n_fail++; $display("FAIL review_%0d got %h exp %h", i, {bus.disp_red, bus.disp_white}, exp_seq[i]); end
    end
    bus.review_mode = 1'b0;
    tick();
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h03) begin n_fail++; $display("FAIL review_exit got %h exp 03", {bus.disp_red, bus.disp_white}); end
  endtask
`else
  task automatic test_review();
    new_game();
    guess(3'd1, 3'd1); guess(3'd2, 3'd0); guess(3'd0, 3'd3);
    bus.review_mode = 1'b1;
    bus.review_step = 1'b1;
    tick();
    bus.review_step = 1'b0;
    tick();
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h03) begin n_fail++; $display("FAIL review_ignored got %h exp 03", {bus.disp_red, bus.disp_white}); end
    bus.review_mode = 1'b0;
  endtask
`endif

  task automatic test_reset_midgame();
    new_game();
    for (int i = 0; i < 5; i++) guess(3'd1, 3'd2);
    bus.review_mode = 1'b1;
    bus.review_step = 1'b1;
    tick();
    bus.review_step = 1'b0;
    n_tests++; if (bus.guess_count !== 4'd5) begin n_fail++; $display("FAIL mid_count got %0d exp 5", bus.guess_count); end
    resetn = 1'b0;
    tick();
    n_tests++; if (bus.guess_count !== 4'd0 || bus.game_state !== 2'b00 || {bus.disp_red, bus.disp_white} !== 8'h00 || bus.fb_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset count/state/disp/err got %0d/%0d/%h/%0d exp 0/0/00/0", bus.guess_count, bus.game_state, {bus.disp_red, bus.disp_white}, bus.fb_err); end
    resetn = 1'b1;
    tick();
    n_tests++; if ({bus.disp_red, bus.disp_white} !== 8'h00 || bus.guess_count !== 4'd0) begin n_fail++; $display("FAIL post_reset disp/count got %h/%0d exp 00/0", {bus.disp_red, bus.disp_white}, bus.guess_count); end
    bus.review_mode = 1'b0;
  endtask

  initial begin
    bus.new_game = 1'b0; bus.fb_valid = 1'b0; bus.fb_red = 3'd0; bus.fb_white = 3'd0;
    bus.review_mode = 1'b0; bus.review_step = 1'b0;
    test_reset();
    test_basic();
    test_win();
    test_lose();
    test_illegal();
    test_review();
    test_reset_midgame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
